// File: rtl/dot_pkg.sv
// Shared types and sizing helpers for the sequential dot-product engine.
package dot_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Exact accumulator width: a full 2N-bit product plus headroom for MAX_LEN terms.
  function automatic int acc_w(input int n, input int max_len);
    return 2 * n + $clog2(max_len);
  endfunction

endpackage

// File: rtl/mac_su.sv
// Combinational multiply-accumulate: acc + ext(a)*ext(b).
// ext() sign-extends when sgn is set and zero-extends otherwise.
module mac_su
  import dot_pkg::*;
#(
  parameter int N     = 8,
  parameter int ACC_W = 19
) (
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [ACC_W-1:0] acc,
  input  logic             sgn,
  output logic [ACC_W-1:0] sum
);

  logic [ACC_W-1:0] ea, eb;

  // Widen both operands to ACC_W.
  // The product truncated to ACC_W is then exact in two's complement.
  always_comb begin
    ea  = sgn ? {{(ACC_W-N){a[N-1]}}, a} : {{(ACC_W-N){1'b0}}, a};
    eb  = sgn ? {{(ACC_W-N){b[N-1]}}, b} : {{(ACC_W-N){1'b0}}, b};
    sum = acc + ea * eb;
  end

endmodule

// File: rtl/dot_product_seq.sv
// Sequential dot-product engine.
// Streams (a, b) beats, accumulates their products and presents the sum
// on a held valid/ready output.
module dot_product_seq
  import dot_pkg::*;
#(
  parameter int N       = 8,
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int ACC_W   = acc_w(N, MAX_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             sgn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] y,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] y_q, y_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             sgn_q, sgn_d;
  logic [ACC_W-1:0] mac_sum;
  logic [LEN_W-1:0] len_c;
  logic [LEN_W-1:0] cnt_inc;

  mac_su #(.N(N), .ACC_W(ACC_W)) u_mac (
    .a   (a),
    .b   (b),
    .acc (acc_q),
    .sgn (sgn_q),
    .sum (mac_sum)
  );

  // Clamp the requested length so count can never run past MAX_LEN.
  assign len_c   = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
  assign cnt_inc = cnt_q + LEN_W'(1);

  // Handshake outputs are pure state decodes, so no input-to-output comb path exists.
  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign y         = y_q;

  // Next-state logic: job setup, beat accumulation and output handoff.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sgn_d   = sgn_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          cnt_d = '0;
          len_d = len_c;
          sgn_d = sgn;
          if (len_c == '0) begin
            state_d = OUT;
            y_d     = '0;
          end else begin
            state_d = ACC;
          end
        end
      end
      ACC: begin
        if (in_valid) begin
          acc_d = mac_sum;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = OUT;
            y_d     = mac_sum;
          end
        end
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any job and drops a coincident start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      sgn_q   <= 1'b0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sgn_q   <= sgn_d;
      y_q     <= y_d;
    end
  end

endmodule

// File: tb/tb_dot_product_seq.sv
// Scoreboard bench for dot_product_seq: directed jobs with hand-computed sums.
module tb_dot_product_seq;

  localparam int N       = 8;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int ACC_W   = 19;

  typedef struct {
    logic [ACC_W-1:0] y;
    int               t;
  } exp_t;

  typedef struct {
    string  nm;
    longint act;
    longint exp;
  } chk_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             sgn = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     a = '0;
  logic [N-1:0]     b = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] y;
  logic             busy;

  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  exp_t exp_q[$];
  chk_t chk_q[$];
  int   va[16];
  int   vb[16];

  dot_product_seq #(.N(N), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .sgn(sgn),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: owns the counters; drains stimulus-side checks and scores every output.
  initial begin
    chk_t             c;
    exp_t             e;
    bit               hold;
    logic [ACC_W-1:0] y_prev;
    hold   = 1'b0;
    y_prev = '0;
    forever begin
      @(negedge clk);
      while (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        nvec++;
        if (c.act !== c.exp) begin
          nerr++;
          $display("FAIL %s: got %0d expected %0d", c.nm, c.act, c.exp);
        end
      end
      if (out_valid && !hold) begin
        nvec++;
        if (exp_q.size() == 0) begin
          nerr++;
          $display("FAIL unexpected_out: got y=%0d at cycle %0d expected no output", y, cyc);
        end else begin
          e = exp_q.pop_front();
          if (y !== e.y) begin
            nerr++;
            $display("FAIL y: got %0d (0x%0h) expected %0d (0x%0h)", y, y, e.y, e.y);
          end
          nvec++;
          if (cyc != e.t) begin
            nerr++;
            $display("FAIL latency: got cycle %0d expected cycle %0d", cyc, e.t);
          end
        end
      end else if (out_valid && hold) begin
        nvec++;
        if (y !== y_prev) begin
          nerr++;
          $display("FAIL y_stable: got %0d expected %0d", y, y_prev);
        end
      end
      hold   = out_valid && !out_ready;
      y_prev = y;
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    chk_t c;
    c.nm = nm; c.act = act; c.exp = exp;
    chk_q.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100 && busy; k++) tick();
    chk("idle_timeout", longint'(busy), 0);
  endtask

  // One job: start, nb beats from va/vb with gap bubbles, optional output stall.
  task automatic run_job(input bit s, input int ln, input int nb, input int gap,
                         input int ey, input int hold, input bit pulse);
    exp_t e;
    int   cl;
    int   t;
    int   k;
    cl = (ln > MAX_LEN) ? MAX_LEN : ln;
    if (hold > 0) out_ready = 1'b0;
    tick();
    start = 1'b1; len = LEN_W'(ln); sgn = s;
    tick();
    start = 1'b0;
    t = cyc;
    e.y = ACC_W'(ey);
    e.t = t + cl + ((cl > 0) ? gap * (cl - 1) : 0);
    exp_q.push_back(e);
    for (int i = 0; i < nb; i++) begin
      in_valid = 1'b1; a = N'(va[i]); b = N'(vb[i]);
      chk("in_ready", longint'(in_ready), (i < cl) ? 1 : 0);
      if (pulse && i == 1) begin start = 1'b1; len = LEN_W'(1); end
      tick();
      start = 1'b0;
      if (gap > 0) begin
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
          chk("busy_bubble", longint'(busy), 1);
          tick();
        end
      end
    end
    in_valid = 1'b0;
    if (hold > 0) begin
      for (k = 0; k < 50 && !out_valid; k++) tick();
      chk("out_valid_wait", longint'(out_valid), 1);
      for (int h = 0; h < hold; h++) begin
        chk("busy_hold", longint'(busy), 1);
        tick();
      end
      out_ready = 1'b1;
    end
    wait_idle();
  endtask

  task automatic fill(input int av, input int bv);
    for (int i = 0; i < 16; i++) begin va[i] = av; vb[i] = bv; end
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_y", longint'(y), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_busy", longint'(busy), 0);

    // signed ramp 1..8 times 1
    for (int i = 0; i < 8; i++) begin va[i] = i + 1; vb[i] = 1; end
    run_job(1'b1, 8, 8, 0, 36, 0, 1'b0);

    // signed extremes
    fill(8'h80, 8'h80);
    run_job(1'b1, 8, 8, 0, 131072, 0, 1'b0);
    fill(8'h80, 8'h7f);
    run_job(1'b1, 8, 8, 0, -130048, 0, 1'b0);

    // 0xFF unsigned vs signed
    fill(8'hff, 8'hff);
    run_job(1'b0, 4, 4, 0, 260100, 0, 1'b0);
    run_job(1'b1, 4, 4, 0, 4, 0, 1'b0);

    // zero length, then clamp 12 -> 8 with a ninth beat offered
    run_job(1'b0, 0, 0, 0, 0, 0, 1'b0);
    fill(1, 1);
    run_job(1'b0, 12, 9, 0, 8, 0, 1'b0);

    // flow control: bubbles between beats and a stalled consumer
    va[0] = 2; va[1] = 3; va[2] = 4;
    vb[0] = 5; vb[1] = 6; vb[2] = 7;
    run_job(1'b0, 3, 3, 2, 56, 3, 1'b0);

    // start pulsed mid-job must be ignored
    fill(3, 3);
    run_job(1'b1, 5, 5, 0, 45, 0, 1'b1);

    // reset abort after two of five beats
    fill(10, 10);
    tick();
    start = 1'b1; len = 4'd5; sgn = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; a = 8'd10; b = 8'd10;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", longint'(busy), 0);
    chk("abort_y", longint'(y), 0);
    chk("abort_out_valid", longint'(out_valid), 0);
    chk("abort_in_ready", longint'(in_ready), 0);

    // rst and start together: start dropped
    rst = 1'b1; start = 1'b1; len = 4'd2;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", longint'(busy), 0);

    // fresh job after abort carries no residue
    va[0] = 3; va[1] = 4; vb[0] = 5; vb[1] = 6;
    run_job(1'b1, 2, 2, 0, 39, 0, 1'b0);

    repeat (4) tick();
    chk("scoreboard_empty", longint'(exp_q.size()), 0);
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
